// File: rtl/i2c_init_sequencer_pkg.sv
// Shared command-table types for the I2C init sequencer.
package i2c_init_sequencer_pkg;

    // Table entry opcode.
    typedef enum logic [1:0] {
        SEQ_NOP   = 2'd0,
        SEQ_WRITE = 2'd1,
        SEQ_DELAY = 2'd2,
        SEQ_END   = 2'd3
    } i2c_seq_op_e;

    // One command-table entry: 25 bits, op in the MSBs.
    typedef struct packed {
        i2c_seq_op_e op;
        logic [6:0]  dev;
        logic [7:0]  reg_addr;
        logic [7:0]  data;
    } i2c_seq_cmd_t;

    localparam int unsigned I2C_SEQ_CMD_WIDTH = $bits(i2c_seq_cmd_t);

    // TX word for a plain write byte: rw=0 in bit 8.
    function automatic logic [8:0] tx_write_byte(input logic [7:0] b);
        return {1'b0, b};
    endfunction

endpackage

// File: rtl/i2c_init_sequencer.sv
// Table-driven I2C configuration sequencer: fetches command entries, pushes
// register writes into the I2C master TX stream, checks ACK with retry and
// timeout, and inserts programmed delays.
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter int unsigned TBL_DEPTH      = 256,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned DELAY_UNIT     = 1000
) (
    input  logic                              clk_i,
    input  logic                              arstn_i,
    input  logic                              start_i,
    output logic [$clog2(TBL_DEPTH)-1:0]      tbl_addr_o,
    input  logic [I2C_SEQ_CMD_WIDTH-1:0]      tbl_data_i,
    output logic [8:0]                        tx_tdata_o,
    output logic                              tx_tvalid_o,
    input  logic                              tx_tready_i,
    input  logic                              busy_i,
    input  logic                              rx_ack_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic [$clog2(TBL_DEPTH)-1:0]      err_idx_o
);

    localparam int unsigned IDXW = $clog2(TBL_DEPTH);
    localparam int unsigned TMW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DLW  = 8 + $clog2(DELAY_UNIT);
    localparam int unsigned CW   = (TMW > DLW) ? TMW : DLW;
    localparam int unsigned RW   = $clog2(MAX_RETRY + 2);

    localparam logic [CW-1:0]   TMO_LOAD  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   DLY_UNIT  = CW'(DELAY_UNIT);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(TBL_DEPTH - 1);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, SEND_DEV, SEND_REG, SEND_DAT,
        WAIT_HI, WAIT_LO, DLY, NEXT, FIN
    } state_e;

    state_e          state, state_nxt;
    logic [IDXW-1:0] idx, idx_nxt;
    logic [RW-1:0]   retry, retry_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [6:0]      dev, dev_nxt;
    logic [7:0]      reg_addr, reg_addr_nxt;
    logic [7:0]      data, data_nxt;
    logic            err, err_nxt;
    logic [IDXW-1:0] err_idx, err_idx_nxt;
    logic            fail;
    logic            tx_valid;
    logic [8:0]      tx_data;
    i2c_seq_cmd_t    cmd_in;

    assign cmd_in = tbl_data_i;

    // State and datapath registers; reset aborts any run immediately.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state    <= IDLE;
            idx      <= '0;
            retry    <= '0;
            cnt      <= '0;
            dev      <= '0;
            reg_addr <= '0;
            data     <= '0;
            err      <= 1'b0;
            err_idx  <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            retry    <= retry_nxt;
            cnt      <= cnt_nxt;
            dev      <= dev_nxt;
            reg_addr <= reg_addr_nxt;
            data     <= data_nxt;
            err      <= err_nxt;
            err_idx  <= err_idx_nxt;
        end
    end

    // Next-state, counter updates and TX byte selection.
    // The single down-counter is reloaded on entry to WAIT_HI, WAIT_LO and DLY;
    // a failed attempt is resolved after the case so both wait states share it.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        retry_nxt    = retry;
        cnt_nxt      = cnt;
        dev_nxt      = dev;
        reg_addr_nxt = reg_addr;
        data_nxt     = data;
        err_nxt      = err;
        err_idx_nxt  = err_idx;
        fail         = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = FETCH;
                    idx_nxt   = '0;
                    retry_nxt = '0;
                    err_nxt   = 1'b0;
                end
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                dev_nxt      = cmd_in.dev;
                reg_addr_nxt = cmd_in.reg_addr;
                data_nxt     = cmd_in.data;
                unique case (cmd_in.op)
                    SEQ_WRITE: state_nxt = SEND_DEV;
                    SEQ_DELAY: begin
                        if (cmd_in.data == 8'd0) begin
                            state_nxt = NEXT;
                        end else begin
                            state_nxt = DLY;
                            cnt_nxt   = CW'(cmd_in.data) * DLY_UNIT - CW'(1);
                        end
                    end
                    SEQ_END:  state_nxt = FIN;
                    default:  state_nxt = NEXT;
                endcase
            end
            SEND_DEV: begin
                tx_valid = 1'b1;
                tx_data  = tx_write_byte({dev, 1'b0});
                if (tx_tready_i) state_nxt = SEND_REG;
            end
            SEND_REG: begin
                tx_valid = 1'b1;
                tx_data  = tx_write_byte(reg_addr);
                if (tx_tready_i) state_nxt = SEND_DAT;
            end
            SEND_DAT: begin
                tx_valid = 1'b1;
                tx_data  = tx_write_byte(data);
                if (tx_tready_i) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = TMO_LOAD;
                end
            end
            WAIT_HI: begin
                if (busy_i) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = TMO_LOAD;
                end else if (cnt == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WAIT_LO: begin
                if (!busy_i) begin
                    if (rx_ack_i) state_nxt = NEXT;
                    else          fail      = 1'b1;
                end else if (cnt == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DLY: begin
                if (cnt == '0) state_nxt = NEXT;
                else           cnt_nxt   = cnt - CW'(1);
            end
            NEXT: begin
                retry_nxt = '0;
                if (idx == LAST_IDX) begin
                    state_nxt = FIN;
                end else begin
                    idx_nxt   = idx + IDXW'(1);
                    state_nxt = FETCH;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (fail) begin
            if (retry < RETRY_MAX) begin
                retry_nxt = retry + RW'(1);
                state_nxt = SEND_DEV;
            end else begin
                err_nxt     = 1'b1;
                err_idx_nxt = idx;
                state_nxt   = FIN;
            end
        end
    end

    assign tbl_addr_o  = idx;
    assign tx_tvalid_o = tx_valid;
    assign tx_tdata_o  = tx_data;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == FIN);
    assign err_o       = err;
    assign err_idx_o   = err_idx;

endmodule
